// File: rtl/roberto_sensor_scheduler.sv
// Round-robin trigger of three ultrasonic sensors, framing each BCD result as ASCII on one TX channel.
// Optional macro ROBERTO_SCHED_TIMEOUT_EN enables the per-sensor measurement watchdog.
module roberto_sensor_scheduler #(
   parameter int TIMEOUT_CICLOS = 3_000_000,
   parameter int PERIODO_CICLOS = 5_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic        continuo,
   input  logic [2:0]  pronto_med,
   input  logic [11:0] medida1,
   input  logic [11:0] medida2,
   input  logic [11:0] medida3,
   input  logic        pronto_tx,
   output logic [2:0]  medir,
   output logic        partida_tx,
   output logic [6:0]  dado_tx,
   output logic [2:0]  erro,
   output logic        pronto,
   output logic [3:0]  db_estado
);

   typedef enum logic [3:0] {
      OCIOSO     = 4'd0,
      MEDE       = 4'd1,
      ESPERA_MED = 4'd2,
      CARREGA    = 4'd3,
      TRANSMITE  = 4'd4,
      ESPERA_TX  = 4'd5,
      PROXIMO    = 4'd6,
      FIM        = 4'd7,
      AGUARDA    = 4'd8
   } estado_t;

   localparam int PER_W = $clog2(PERIODO_CICLOS);

   if (TIMEOUT_CICLOS < 2 || PERIODO_CICLOS < 2) begin : g_param_check
      $error("roberto_sensor_scheduler: TIMEOUT_CICLOS and PERIODO_CICLOS must be at least 2");
   end

   estado_t          estado_reg, estado_next;
   logic [1:0]       idx_reg, idx_next;
   logic [1:0]       char_reg, char_next;
   logic [11:0]      med_reg, med_next;
   logic [PER_W-1:0] per_reg, per_next;
   logic [2:0]       erro_reg, erro_next;
   logic [2:0]       medir_reg, medir_next;
   logic             partida_reg, partida_next;
   logic [6:0]       dado_reg, dado_next;
   logic             pronto_reg, pronto_next;

`ifdef ROBERTO_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CICLOS);
   logic [WD_W-1:0]  wd_reg, wd_next;
`endif

   logic [11:0] medida_vet [3];
   logic [6:0]  digito_ascii [3];
   logic [6:0]  char_ascii;

   assign medida_vet[0] = medida1;
   assign medida_vet[1] = medida2;
   assign medida_vet[2] = medida3;

   // Hundreds digit is character 0; a timed-out sensor or a non-BCD nibble prints '-'
   for (genvar gi = 0; gi < 3; gi++) begin : g_digito
      logic [3:0] bcd;
      assign bcd = med_reg[4*(2-gi) +: 4];
      assign digito_ascii[gi] = (erro_reg[idx_reg] || (bcd > 4'd9)) ? 7'h2D : (7'h30 + {3'b000, bcd});
   end

   always_comb begin
      estado_next = estado_reg;
      idx_next    = idx_reg;
      char_next   = char_reg;
      med_next    = med_reg;
      per_next    = per_reg;
      erro_next   = erro_reg;
      dado_next   = dado_reg;
`ifdef ROBERTO_SCHED_TIMEOUT_EN
      wd_next     = wd_reg;
`endif

      case (estado_reg)
         OCIOSO: begin
            if (iniciar) begin
               erro_next   = 3'b000;
               idx_next    = 2'd0;
               estado_next = MEDE;
            end
         end
         MEDE: begin
`ifdef ROBERTO_SCHED_TIMEOUT_EN
            wd_next     = '0;
`endif
            estado_next = ESPERA_MED;
         end
         ESPERA_MED: begin
            // A measurement arriving on the expiry cycle takes priority over the timeout
            if (pronto_med[idx_reg]) begin
               med_next    = medida_vet[idx_reg];
               estado_next = CARREGA;
            end
`ifdef ROBERTO_SCHED_TIMEOUT_EN
            else if (wd_reg == WD_W'(TIMEOUT_CICLOS - 1)) begin
               erro_next[idx_reg] = 1'b1;
               estado_next        = CARREGA;
            end else begin
               wd_next = wd_reg + 1'b1;
            end
`endif
         end
         CARREGA: begin
            char_next   = 2'd0;
            estado_next = TRANSMITE;
         end
         TRANSMITE: begin
            estado_next = ESPERA_TX;
         end
         ESPERA_TX: begin
            if (pronto_tx) begin
               if (char_reg != 2'd3) begin
                  char_next   = char_reg + 2'd1;
                  estado_next = TRANSMITE;
               end else begin
                  estado_next = PROXIMO;
               end
            end
         end
         PROXIMO: begin
            if (idx_reg != 2'd2) begin
               idx_next    = idx_reg + 2'd1;
               estado_next = MEDE;
            end else begin
               estado_next = FIM;
            end
         end
         FIM: begin
            per_next    = '0;
            estado_next = continuo ? AGUARDA : OCIOSO;
         end
         AGUARDA: begin
            if (!continuo) begin
               estado_next = OCIOSO;
            end else if (per_reg == PER_W'(PERIODO_CICLOS - 1)) begin
               erro_next   = 3'b000;
               idx_next    = 2'd0;
               estado_next = MEDE;
            end else begin
               per_next = per_reg + 1'b1;
            end
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state they belong to
      char_ascii   = (char_next == 2'd3) ? ((idx_reg == 2'd2) ? 7'h23 : 7'h2C) : digito_ascii[char_next];
      medir_next   = (estado_next == MEDE) ? (3'b001 << idx_next) : 3'b000;
      partida_next = (estado_next == TRANSMITE);
      pronto_next  = (estado_next == FIM);
      if (estado_next == TRANSMITE) begin
         dado_next = char_ascii;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_reg  <= OCIOSO;
         idx_reg     <= 2'd0;
         char_reg    <= 2'd0;
         med_reg     <= 12'h000;
         per_reg     <= '0;
         erro_reg    <= 3'b000;
         medir_reg   <= 3'b000;
         partida_reg <= 1'b0;
         dado_reg    <= 7'h00;
         pronto_reg  <= 1'b0;
      end else begin
         estado_reg  <= estado_next;
         idx_reg     <= idx_next;
         char_reg    <= char_next;
         med_reg     <= med_next;
         per_reg     <= per_next;
         erro_reg    <= erro_next;
         medir_reg   <= medir_next;
         partida_reg <= partida_next;
         dado_reg    <= dado_next;
         pronto_reg  <= pronto_next;
      end
   end

`ifdef ROBERTO_SCHED_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_reg <= '0;
      end else begin
         wd_reg <= wd_next;
      end
   end
`endif

   assign medir      = medir_reg;
   assign partida_tx = partida_reg;
   assign dado_tx    = dado_reg;
   assign erro       = erro_reg;
   assign pronto     = pronto_reg;
   assign db_estado  = estado_reg;

endmodule
